im_loader: RTL
==============

# im_loader

Writable instruction memory with a byte-stream program loader for the hardwired-controller core. The loader accepts a length header and big-endian 16-bit instruction words over a valid/ready byte handshake, and writes them into a 16-entry RAM. It holds the core in reset while a load is in progress. The fetch side keeps the same combinational `iAddr`/`oData` read port as the fixed instruction ROM, so the core can fetch from either without changes.

## Interface
Parameters:
- `DW`, 16: instruction word width.
- `AW`, 4: address width; depth is 2^AW = 16.

Ports:
- `iClk`  in  1  the single clock; all state updates on its rising edge.
- `iRst_n`  in  1  synchronous, active-low reset.
- `iStart`  in  1  one-cycle pulse that starts a load; honoured only in IDLE.
- `iByte`  in  8  loader data byte.
- `iByteValid`  in  1  `iByte` is valid.
- `oByteReady`  out  1  loader can accept a byte; a transfer occurs when `iByteValid` and `oByteReady` are both high on a rising edge.
- `oCpuRst_n`  out  1  reset to the core; low while a load is in progress.
- `oDone`  out  1  one-cycle pulse when a load completes successfully.
- `oErr`  out  1  sticky flag for a bad length header; cleared by `iRst_n` or the next accepted `iStart`.
- `iAddr`  in  AW  fetch address.
- `oData`  out  DW  fetch data; combinational: `oData = mem[iAddr]`.

## Operation
- The FSM has five states: IDLE, HDR, HI, LO, DONE.
- IDLE:
  - `oByteReady` = 0.
  - `iStart` = 1 -> go to HDR, set `oCpuRst_n` = 0, clear `oErr`, clear the write pointer `wp` to 0.
  - Bytes presented in IDLE are not accepted.
- HDR:
  - `oByteReady` = 1.
  - On a transfer, the byte is the word count N.
  - N in 1..16: latch `cnt` = N (5-bit register), go to HI.
  - N = 0 or N > 16: set `oErr` = 1, set `oCpuRst_n` = 1, go to IDLE. Memory is not changed.
- HI:
  - `oByteReady` = 1.
  - On a transfer, latch `hi` = `iByte` and go to LO.
- LO:
  - `oByteReady` = 1.
  - On a transfer:
    - Write `mem[wp]` = {`hi`, `iByte`}.
    - `wp` += 1, wrapping modulo 16.
    - `cnt` -= 1.
    - If `cnt` was 1, go to DONE; otherwise go to HI.
- DONE:
  - `oByteReady` = 0, `oDone` = 1 for exactly this cycle.
  - Next cycle: `oCpuRst_n` = 1, go to IDLE.
- While no transfer happens, each state holds and no register changes; gaps between bytes are allowed.
- `iStart` outside IDLE is ignored and does not restart the load.
- `mem` is not cleared by reset. Words not written by a load keep their previous contents.
- Write/read collision: if `iAddr` == `wp` during a LO write, `oData` shows the old word in that cycle and the new word from the next cycle.

## Timing
- Reset values: state IDLE, `oByteReady` 0, `oCpuRst_n` 1, `oDone` 0, `oErr` 0, `wp` 0, `cnt` 0, `hi` 0.
- Reset asserted mid-load: everything returns to the reset values at the next edge. Words already written stay in memory; the partial word in `hi` is discarded.
- `iStart` at edge t -> `oCpuRst_n` = 0 and `oByteReady` = 1 from t+1.
- Minimum load time with `iByteValid` held high: 1 + 2N transfer cycles after the start edge, then one DONE cycle.
- `oDone` and `oCpuRst_n` timing: `oDone` is high for the one cycle after the final LO transfer. `oCpuRst_n` returns to 1 in the cycle after `oDone`.
- `oByteReady` depends only on state, never on `iByteValid`, so there is no combinational path from input to `oByteReady`.
- `oData` has zero-cycle latency from `iAddr`. A written word is visible on `oData` from the cycle after its LO transfer.

## Test plan
- **Basic load:** `iStart`, then bytes 04, 18,15, 20,2A, 09,B0, 2E,C0 with `iByteValid` held high.
  - `mem[0..3]` = 1815, 202A, 09B0, 2EC0.
  - `oDone` high for exactly 1 cycle, 10 cycles after the start edge.
  - `oCpuRst_n` is low from start+1 through the `oDone` cycle.
- **Backpressure gaps:** same stream with `iByteValid` deasserted for 3 cycles between each byte.
  - Identical memory contents; nothing is written during the gaps.
- **Bad headers:**
  - Header 00: `oErr` = 1, `oCpuRst_n` returns to 1, `mem` unchanged, FSM back in IDLE.
  - Header 11 (17): same response.
  - A following `iStart` clears `oErr`.
- **Full depth and wrap:** header 10 (16) with words 0000..000F.
  - `mem[i]` = i for all 16 entries.
  - `wp` wraps to 0.
  - A second 2-word load writes `mem[0]` and `mem[1]`; entries 2..15 keep their values.
- **Reset and start interactions:**
  - Assert `iRst_n` = 0 after the 2nd word of a 4-word load: `mem[0..1]` are written, `mem[2..3]` are unchanged, all outputs at reset values.
  - `iStart` pulsed during HI is ignored.
- **Fetch collision:** hold `iAddr` = 2 while word 2 is written.
  - `oData` shows the old value in the write cycle and the new value on the next cycle.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: writable 16-word instruction memory filled by a length-prefixed,
// big-endian byte stream; holds the core in reset while a load is in progress.
module im_loader #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iStart,
  input  logic [7:0]    iByte,
  input  logic          iByteValid,
  output logic          oByteReady,
  output logic          oCpuRst_n,
  output logic          oDone,
  output logic          oErr,
  input  logic [AW-1:0] iAddr,
  output logic [DW-1:0] oData
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, DONE} state_t;

  state_t        state;
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;
  logic [7:0]    hi;
  logic [DW-1:0] mem [DEPTH];

  logic xfer;
  logic hdr_ok;
  logic wr_en;

  assign xfer   = iByteValid && oByteReady;
  assign hdr_ok = (iByte != 8'd0) && (32'(iByte) <= DEPTH);
  // A reset on the same edge as a low-byte transfer suppresses the write.
  assign wr_en  = xfer && (state == LO) && iRst_n;

  // Fetch port is a plain combinational read; a same-cycle write shows next cycle.
  assign oData = mem[iAddr];

  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem[wp] <= DW'({hi, iByte});
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state      <= IDLE;
      oByteReady <= 1'b0;
      oCpuRst_n  <= 1'b1;
      oDone      <= 1'b0;
      oErr       <= 1'b0;
      wp         <= '0;
      cnt        <= '0;
      hi         <= '0;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            state      <= HDR;
            oByteReady <= 1'b1;
            oCpuRst_n  <= 1'b0;
            oErr       <= 1'b0;
            wp         <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_ok) begin
              cnt   <= CW'(iByte);
              state <= HI;
            end else begin
              oErr       <= 1'b1;
              oCpuRst_n  <= 1'b1;
              oByteReady <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        HI: begin
          if (xfer) begin
            hi    <= iByte;
            state <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            wp  <= wp + AW'(1);
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state      <= DONE;
              oByteReady <= 1'b0;
              oDone      <= 1'b1;
            end else begin
              state <= HI;
            end
          end
        end
        DONE: begin
          oCpuRst_n <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
